// File: rtl/userdma_df_scheduler.sv
// userdma_df_scheduler: launch/run/done sequencer for the userdma dataflow region.
// Optional stall watchdog enabled by defining USERDMA_DF_WDOG_EN.
module userdma_df_scheduler #(
    parameter int NUM_PROC    = 5,
    parameter int CNT_W       = 16,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ap_start,
    input  logic                ap_continue,
    output logic                ap_ready,
    output logic                ap_done,
    output logic                ap_idle,
    output logic [NUM_PROC-1:0] proc_start,
    input  logic [NUM_PROC-1:0] proc_ready,
    input  logic [NUM_PROC-1:0] proc_done,
    input  logic [NUM_PROC-1:0] proc_idle,
    input  logic [NUM_PROC-1:0] proc_blocked,
    output logic [NUM_PROC-1:0] proc_continue,
    output logic [CNT_W-1:0]    iter_count,
    output logic                stall,
    output logic [NUM_PROC-1:0] stall_vec
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_PROC-1:0] ready_seen_q, ready_seen_d;
    logic [NUM_PROC-1:0] done_seen_q, done_seen_d;
    logic [CNT_W-1:0]    iter_q, iter_d;
    logic                ap_done_q;
    logic                ap_idle_q;
    logic                in_launch;
    logic                in_done;
    logic                cont_fire;

    assign in_launch = (state_q == S_LAUNCH);
    assign in_done   = (state_q == S_DONE);
    assign cont_fire = in_done & ap_continue;

    // Next-state and sticky ready/done bookkeeping
    always_comb begin
        state_d      = state_q;
        ready_seen_d = ready_seen_q;
        done_seen_d  = done_seen_q;
        iter_d       = iter_q;
        unique case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                ready_seen_d = ready_seen_q | proc_ready;
                // a fast process may report done together with ready
                done_seen_d  = done_seen_q | proc_done;
                if (&ready_seen_d) begin
                    ready_seen_d = '0;
                    state_d      = S_RUN;
                end
            end
            S_RUN: begin
                done_seen_d = done_seen_q | proc_done;
                if (&done_seen_d) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ap_continue) begin
                    done_seen_d = '0;
                    iter_d      = iter_q + CNT_W'(1);
                    state_d     = ap_start ? S_LAUNCH : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, bookkeeping and registered status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ready_seen_q <= '0;
            done_seen_q  <= '0;
            iter_q       <= '0;
            ap_done_q    <= 1'b0;
            ap_idle_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_seen_q <= ready_seen_d;
            done_seen_q  <= done_seen_d;
            iter_q       <= iter_d;
            ap_done_q    <= (state_d == S_DONE);
            ap_idle_q    <= (state_q == S_IDLE) & (&proc_idle);
        end
    end

    assign proc_start    = in_launch ? ~ready_seen_q : '0;
    assign ap_ready      = in_launch & (&(ready_seen_q | proc_ready));
    assign proc_continue = {NUM_PROC{cont_fire}};
    assign ap_done       = ap_done_q;
    assign ap_idle       = ap_idle_q;
    assign iter_count    = iter_q;

`ifdef USERDMA_DF_WDOG_EN
    localparam int WC_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(WDOG_CYCLES - 1);

    logic [WC_W-1:0]     wcnt_q;
    logic                stall_q;
    logic [NUM_PROC-1:0] stall_vec_q;
    logic                wd_active;
    logic                wd_stopped;
    logic                wd_rearm;

    assign wd_active  = in_launch | (state_q == S_RUN);
    // every process is parked and at least one is held by back-pressure
    assign wd_stopped = (&(proc_idle | done_seen_q | proc_blocked))
                      & (|proc_blocked);
    assign wd_rearm   = (state_q == S_IDLE) & ap_start;

    // Saturating stall counter with sticky flag and blocked snapshot
    always_ff @(posedge clock) begin
        if (reset) begin
            wcnt_q      <= '0;
            stall_q     <= 1'b0;
            stall_vec_q <= '0;
        end else if (wd_rearm) begin
            wcnt_q      <= '0;
            stall_q     <= 1'b0;
            stall_vec_q <= '0;
        end else if (!wd_active || !wd_stopped) begin
            wcnt_q <= '0;
        end else if (wcnt_q == WC_MAX) begin
            if (!stall_q) begin
                stall_q     <= 1'b1;
                stall_vec_q <= proc_blocked;
            end
        end else begin
            wcnt_q <= wcnt_q + WC_W'(1);
        end
    end

    assign stall     = stall_q;
    assign stall_vec = stall_vec_q;
`else
    logic unused_wdog;

    assign unused_wdog = (^proc_blocked) ^ (WDOG_CYCLES < 2);
    assign stall       = 1'b0;
    assign stall_vec   = '0;
`endif

endmodule
